// File: rtl/regfile_mp_pkg.sv
// Shared constants and FSM encoding for the multi-port register file.
// Defaults match the dual-issue pipeline: 32 x 32-bit, 4 read ports, 2 write ports.
package regfile_mp_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 4;
    localparam int RF_NUM_WR = 2;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Pipeline-side bus of the register file: packed read/write ports plus ready.
// The pipeline is the master; the register file is the slave.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR
);
    logic [NUM_RD-1:0]        rdEn;
    logic [NUM_RD*ADDR_W-1:0] rdAddr;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_WR-1:0]        wEn;
    logic [NUM_WR*ADDR_W-1:0] wAddr;
    logic [NUM_WR*DATA_W-1:0] wData;
    logic                     ready;

    modport master (
        output rdEn, rdAddr, wEn, wAddr, wData,
        input  rdData, ready
    );

    modport slave (
        input  rdEn, rdAddr, wEn, wAddr, wData,
        output rdData, ready
    );
endinterface

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks registers 1..DEPTH-1 writing zero, then raises ready.
// Latency: ready rises DEPTH-1 edges after rst falls. No backpressure; restarts on any rst.
module regfile_clr_seq
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        clr_we    = 1'b0;
        clr_addr  = clr_idx_q;
        case (state_q)
            RF_CLEAR: begin
                clr_we    = ~rst;
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end
            end
            RF_RUN:  ;
            default: state_d = RF_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= ADDR_W'(1);
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    assign ready = ready_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, r0 hardwired to zero, hardware-cleared after reset.
// Latency: reads combinational, writes visible next cycle (same cycle with REGFILE_MP_BYPASS_EN).
// Backpressure: none; traffic is ignored until ready, writes are dropped during clear.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  rf
);
    logic                     clr_we;
    logic [ADDR_W-1:0]        clr_addr;
    logic                     ready;
    logic                     wr_ok;
    logic [ADDR_W-1:0]        wr_addr;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        lane;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];

    regfile_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    assign wr_ok = ready & ~rst;

    // Ascending port order makes the highest-numbered port win a same-address collision.
    always_comb begin
        mem_d   = mem_q;
        wr_addr = '0;
        if (clr_we) begin
            mem_d[clr_addr] = '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NUM_WR; k++) begin
                wr_addr = rf.wAddr[k*ADDR_W +: ADDR_W];
                if (rf.wEn[k] && wr_addr != '0) begin
                    mem_d[wr_addr] = rf.wData[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        rd_addr = '0;
        lane    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr = rf.rdAddr[i*ADDR_W +: ADDR_W];
            lane    = '0;
            if (ready && rf.rdEn[i] && rd_addr != '0) begin
                lane = mem_q[rd_addr];
`ifdef REGFILE_MP_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_ok && rf.wEn[k] && rf.wAddr[k*ADDR_W +: ADDR_W] == rd_addr) begin
                        lane = rf.wData[k*DATA_W +: DATA_W];
                    end
                end
`endif
            end
            rd_data[i*DATA_W +: DATA_W] = lane;
        end
    end

    assign rf.rdData = rd_data;
    assign rf.ready  = ready;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus random traffic against an array model,
// with expected responses queued by the driver and checked by an independent monitor.
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int NW    = 2;

    typedef struct packed {
        logic           rdy;
        logic [NR*DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];
    int          m_cnt;
    bit          m_ready;

    // One clock of stimulus: predict this cycle's outputs, then advance the model over the edge.
    task automatic drive(input bit r, input logic [3:0] re,
                         input logic [4:0] a0, a1, a2, a3,
                         input logic [1:0] we, input logic [4:0] wa0, wa1,
                         input logic [31:0] wd0, wd1);
        exp_t        e;
        logic [4:0]  ra [4];
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [31:0] v;
        ra = '{a0, a1, a2, a3};
        wa = '{wa0, wa1};
        wd = '{wd0, wd1};
        rst        = r;
        bus.rdEn   = re;
        bus.rdAddr = {a3, a2, a1, a0};
        bus.wEn    = we;
        bus.wAddr  = {wa1, wa0};
        bus.wData  = {wd1, wd0};
        e.rdy = m_ready;
        e.d   = '0;
        for (int i = 0; i < NR; i++) begin
            v = 32'h0;
            if (m_ready && re[i] && ra[i] != 5'd0) begin
                v = ref_mem[ra[i]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int k = 0; k < NW; k++)
                    if (!r && we[k] && wa[k] == ra[i]) v = wd[k];
`endif
            end
            e.d[i*DW +: DW] = v;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_cnt   = 0;
            m_ready = 1'b0;
            for (int j = 0; j < DEPTH; j++) ref_mem[j] = 32'h0;
        end else if (m_ready) begin
            for (int k = 0; k < NW; k++)
                if (we[k] && wa[k] != 5'd0) ref_mem[wa[k]] = wd[k];
        end else begin
            m_cnt++;
            if (m_cnt == DEPTH - 1) m_ready = 1'b1;
        end
        #1;
    endtask

    task automatic rd4(input logic [4:0] a0, a1, a2, a3);
        drive(1'b0, 4'hf, a0, a1, a2, a3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ready !== e.rdy) begin
                    errors++;
                    $display("FAIL ready t=%0t got %b want %b", $time, bus.ready, e.rdy);
                end
                for (int i = 0; i < NR; i++) begin
                    checks++;
                    if (bus.rdData[i*DW +: DW] !== e.d[i*DW +: DW]) begin
                        errors++;
                        $display("FAIL rdData[%0d] t=%0t got %h want %h", i, $time,
                                 bus.rdData[i*DW +: DW], e.d[i*DW +: DW]);
                    end
                end
            end
        end
    end

    initial begin
        logic [4:0] a [4];
        logic [4:0] w [2];
        bit         r;
        rst = 1'b1;
        bus.rdEn = '0; bus.rdAddr = '0; bus.wEn = '0; bus.wAddr = '0; bus.wData = '0;
        m_cnt = 0;
        m_ready = 1'b0;
        for (int j = 0; j < DEPTH; j++) ref_mem[j] = 32'h0;
        @(posedge clk);
        #1;

        // Reset held, then the clear sequence with a dropped write to r5.
        repeat (3) drive(1'b1, 4'hf, 5'd1, 5'd2, 5'd5, 5'd31, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        for (int c = 0; c < DEPTH - 1; c++) begin
            if (c == 4) drive(1'b0, 4'hf, 5'd5, 5'd1, 5'd2, 5'd3, 2'b01, 5'd5, 5'd0, 32'hBAD0BAD0, 32'h0);
            else        rd4(5'(c), 5'd5, 5'd31, 5'd7);
        end
        for (int j = 0; j < 8; j++)
            rd4(5'(4*j + 1), 5'(4*j + 2), 5'(4*j + 3), 5'(4*j + 4));

        // Dual write, then 4-port read.
        drive(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd7, 5'd9, 32'hDEADBEEF, 32'h12345678);
        rd4(5'd7, 5'd9, 5'd7, 5'd0);

        // Collision on r3.
        drive(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd3, 5'd3, 32'h11111111, 32'h22222222);
        rd4(5'd3, 5'd3, 5'd3, 5'd3);

        // r0 write ignored; lane 2 disabled.
        drive(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0);
        drive(1'b0, 4'b1011, 5'd0, 5'd7, 5'd7, 5'd9, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

        // Same-cycle read of a write target.
        drive(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b10, 5'd0, 5'd10, 32'h0, 32'h1);
        drive(1'b0, 4'hf, 5'd10, 5'd10, 5'd3, 5'd10, 2'b01, 5'd10, 5'd0, 32'hA5A5A5A5, 32'h0);
        rd4(5'd10, 5'd10, 5'd10, 5'd10);

        // Reset in RUN, then again mid-clear; r4 must come back as zero.
        drive(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd4, 5'd0, 32'h55, 32'h0);
        rd4(5'd4, 5'd4, 5'd4, 5'd4);
        drive(1'b1, 4'hf, 5'd4, 5'd7, 5'd9, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        repeat (10) rd4(5'd4, 5'd7, 5'd9, 5'd3);
        drive(1'b1, 4'hf, 5'd4, 5'd7, 5'd9, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        repeat (35) rd4(5'd4, 5'd7, 5'd9, 5'd3);

        // Random traffic with a narrow address range to provoke collisions and forwards.
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < 4; i++)
                a[i] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            for (int k = 0; k < 2; k++) w[k] = 5'($urandom_range(0, 7));
            drive(r, 4'($urandom_range(0, 15)), a[0], a[1], a[2], a[3],
                  r ? 2'b00 : 2'($urandom_range(0, 3)), w[0], w[1], $urandom, $urandom);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
